serv_pc_unit: RTL and testbench

- Parametrised successor to the single-width program-counter unit of the SERV core.
- Supports any datapath slice width W that divides 32 (1, 2, 4, 8, 16, 32).
- Owns its own step counter instead of taking external cnt0/cnt1/cnt2 strobes, and adds vectored trap entry (mtvec MODE=1) and registered misaligned-target detection.
- Sits between the decoder/state block, the CSR block and the instruction bus address; produces the serial rd value for jal/jalr/auipc/lui.

---
 rtl/serv_pc_pkg.sv | 20 ++
 rtl/serv_pc_unit_ser_add.sv | 29 ++
 rtl/serv_pc_unit.sv | 147 ++++++++++++++
 tb/tb_serv_pc_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_pc_pkg.sv
// Shared constants and elaboration helpers for the serial program-counter unit.
package serv_pc_pkg;

  localparam logic [3:0]  INC2      = 4'd2;
  localparam logic [3:0]  INC4      = 4'd4;
  localparam int unsigned VEC_SHIFT = 2;

  function automatic int unsigned num_steps(input int unsigned w);
    return 32 / w;
  endfunction

  function automatic int unsigned step_width(input int unsigned w);
    return (w >= 32) ? 1 : $clog2(32 / w);
  endfunction

  function automatic bit legal_w(input int unsigned w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/serv_pc_unit_ser_add.sv
// W-bit slice of a ripple-serial adder; the carry travels between slices in a register.
module serv_ser_add #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic         carry;
  logic [W:0]   total;

  // Step 0 ignores the stored carry so a previous update never leaks in.
  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (clr ? 1'b0 : carry)};
  assign sum   = total[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= total[W];
    end
  end

endmodule

// File: rtl/serv_pc_unit.sv
// Slice-serial program counter: next PC, jump/trap targets and rd value for jal/jalr/auipc/lui.
module serv_pc_unit
  import serv_pc_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WITH_CSR = 1,
  parameter int unsigned WITH_C   = 0,
  parameter int unsigned VECTORED = 0
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_pc_en,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic         i_irq,
  input  logic [4:0]   i_cause,
  input  logic         i_iscomp,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic [W-1:0] o_bad_pc,
  output logic         o_misalign,
  output logic         o_done,
  output logic [31:0]  o_ibus_adr
);

  localparam int unsigned NSTEPS = num_steps(W);
  localparam int unsigned SW     = step_width(W);

  if (!legal_w(W)) begin : g_bad_w
    $error("serv_pc_unit: W must be 1, 2, 4, 8, 16 or 32");
  end

  logic [SW-1:0]  step;
  logic           cnt0;
  logic           last;
  logic [5:0]     base;
  logic [5:0]     pa;
  logic [5:0]     pb;
  logic [3:0]     inc;
  logic [7:0]     cause_sh;
  logic           trap_en;
  logic [W-1:0]   pc;
  logic [W-1:0]   inc_slice;
  logic [W-1:0]   off_a;
  logic [W-1:0]   off_b;
  logic [W-1:0]   csr_slice;
  logic [W-1:0]   vec_add;
  logic [W-1:0]   pc_plus;
  logic [W-1:0]   off_sum;
  logic [W-1:0]   vec_sum;
  logic [W-1:0]   aligned;
  logic [W-1:0]   new_pc;
  logic           mis_now;
  logic           mis_slice;
  logic           mis_hold;
  logic [W+31:0]  wide;
  logic [31:0]    next_adr;

  assign pc      = o_ibus_adr[W-1:0];
  assign cnt0    = (step == '0);
  assign last    = (step == SW'(NSTEPS - 1));
  assign base    = 6'(step) * 6'(W);
  assign trap_en = (WITH_CSR != 0) && i_trap;
  assign o_done  = i_pc_en && last;

  // Every constant operand is placed by absolute bit position (base + j), so any W works.
  always_comb begin
    inc       = ((WITH_C != 0) && i_iscomp) ? INC2 : INC4;
    cause_sh  = ((VECTORED != 0) && i_irq) ? (8'(i_cause) << VEC_SHIFT) : '0;
    pa        = '0;
    inc_slice = '0;
    off_b     = '0;
    csr_slice = '0;
    vec_add   = '0;
    for (int unsigned j = 0; j < W; j++) begin
      pa           = base + 6'(j);
      inc_slice[j] = (pa < 6'd4) && inc[pa[1:0]];
      off_b[j]     = i_utype ? ((pa >= 6'd12) && i_imm[j]) : i_buf[j];
      csr_slice[j] = (pa >= 6'(VEC_SHIFT)) && i_csr_pc[j];
      vec_add[j]   = (pa < 6'd8) && cause_sh[pa[2:0]];
    end
    off_a = i_pc_rel ? pc : '0;
  end

  serv_ser_add #(.W(W)) u_pc_add (
    .clk(clk), .rst_n(i_rst_n), .en(i_pc_en), .clr(cnt0),
    .a(pc), .b(inc_slice), .sum(pc_plus)
  );

  serv_ser_add #(.W(W)) u_off_add (
    .clk(clk), .rst_n(i_rst_n), .en(i_pc_en), .clr(cnt0),
    .a(off_a), .b(off_b), .sum(off_sum)
  );

  serv_ser_add #(.W(W)) u_vec_add (
    .clk(clk), .rst_n(i_rst_n), .en(i_pc_en), .clr(cnt0),
    .a(csr_slice), .b(vec_add), .sum(vec_sum)
  );

  always_comb begin
    aligned   = off_sum;
    mis_now   = 1'b0;
    mis_slice = 1'b0;
    pb        = '0;
    for (int unsigned j = 0; j < W; j++) begin
      pb = base + 6'(j);
      if (pb == 6'd0) aligned[j] = 1'b0;
      if (pb == 6'd1) begin
        mis_slice = 1'b1;
        mis_now   = off_sum[j] && i_jump && (WITH_C == 0);
      end
    end
  end

  assign new_pc   = trap_en ? vec_sum : (i_jump ? aligned : pc_plus);
  assign o_rd     = (i_utype ? aligned : '0) | (i_jal_or_jalr ? pc_plus : '0);
  assign o_bad_pc = aligned;

  // Widened concatenation keeps the shift legal for W=32 as well.
  assign wide     = {new_pc, o_ibus_adr};
  assign next_adr = wide[W +: 32];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_ibus_adr <= RESET_PC;
      step       <= '0;
      mis_hold   <= 1'b0;
      o_misalign <= 1'b0;
    end else if (i_pc_en) begin
      o_ibus_adr <= next_adr;
      step       <= last ? '0 : step + 1'b1;
      if (mis_slice) mis_hold <= mis_now;
      if (last) begin
        o_misalign <= mis_slice ? mis_now : mis_hold;
      end else if (cnt0) begin
        o_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serv_pc_unit.sv
// Randomized bench for serv_pc_unit at W=1/4/8/32 against a whole-word PC model.
module tb_serv_pc_unit;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump, jal, utype, pc_rel, trap, irq, iscomp;
  logic [4:0]  cause;
  logic [3:0]  pc_en;
  logic [31:0] imm32, buf32, csr32;
  int unsigned s;

  logic [0:0]  imm0, buf0, csr0, rd0, bad0;
  logic [3:0]  imm1, buf1, csr1, rd1, bad1;
  logic [7:0]  imm2, buf2, csr2, rd2, bad2;
  logic [31:0] rd3, bad3;

  logic [31:0] rd_o  [NDUT];
  logic [31:0] bad_o [NDUT];
  logic [31:0] adr_o [NDUT];
  logic        done_o[NDUT];
  logic        mis_o [NDUT];

  logic [31:0] pc_m  [NDUT];
  logic        mis_m [NDUT];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign imm0 = 1'(imm32 >> s);
  assign buf0 = 1'(buf32 >> s);
  assign csr0 = 1'(csr32 >> s);
  assign imm1 = 4'(imm32 >> (s * 4));
  assign buf1 = 4'(buf32 >> (s * 4));
  assign csr1 = 4'(csr32 >> (s * 4));
  assign imm2 = 8'(imm32 >> (s * 8));
  assign buf2 = 8'(buf32 >> (s * 8));
  assign csr2 = 8'(csr32 >> (s * 8));

  assign rd_o[0]  = 32'(rd0);
  assign rd_o[1]  = 32'(rd1);
  assign rd_o[2]  = 32'(rd2);
  assign rd_o[3]  = rd3;
  assign bad_o[0] = 32'(bad0);
  assign bad_o[1] = 32'(bad1);
  assign bad_o[2] = 32'(bad2);
  assign bad_o[3] = bad3;

  serv_pc_unit #(.W(1), .RESET_PC(32'h100), .WITH_CSR(1), .WITH_C(1), .VECTORED(1)) u_d0 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(pc_en[0]), .i_jump(jump), .i_jal_or_jalr(jal),
    .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap), .i_irq(irq), .i_cause(cause),
    .i_iscomp(iscomp), .i_imm(imm0), .i_buf(buf0), .i_csr_pc(csr0), .o_rd(rd0),
    .o_bad_pc(bad0), .o_misalign(mis_o[0]), .o_done(done_o[0]), .o_ibus_adr(adr_o[0]));

  serv_pc_unit #(.W(4), .RESET_PC(32'h100), .WITH_CSR(1), .WITH_C(1), .VECTORED(0)) u_d1 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(pc_en[1]), .i_jump(jump), .i_jal_or_jalr(jal),
    .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap), .i_irq(irq), .i_cause(cause),
    .i_iscomp(iscomp), .i_imm(imm1), .i_buf(buf1), .i_csr_pc(csr1), .o_rd(rd1),
    .o_bad_pc(bad1), .o_misalign(mis_o[1]), .o_done(done_o[1]), .o_ibus_adr(adr_o[1]));

  serv_pc_unit #(.W(8), .RESET_PC(32'h100), .WITH_CSR(1), .WITH_C(0), .VECTORED(1)) u_d2 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(pc_en[2]), .i_jump(jump), .i_jal_or_jalr(jal),
    .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap), .i_irq(irq), .i_cause(cause),
    .i_iscomp(iscomp), .i_imm(imm2), .i_buf(buf2), .i_csr_pc(csr2), .o_rd(rd2),
    .o_bad_pc(bad2), .o_misalign(mis_o[2]), .o_done(done_o[2]), .o_ibus_adr(adr_o[2]));

  serv_pc_unit #(.W(32), .RESET_PC(32'h100), .WITH_CSR(1), .WITH_C(0), .VECTORED(0)) u_d3 (
    .clk(clk), .i_rst_n(rst_n), .i_pc_en(pc_en[3]), .i_jump(jump), .i_jal_or_jalr(jal),
    .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap), .i_irq(irq), .i_cause(cause),
    .i_iscomp(iscomp), .i_imm(imm32), .i_buf(buf32), .i_csr_pc(csr32), .o_rd(rd3),
    .o_bad_pc(bad3), .o_misalign(mis_o[3]), .o_done(done_o[3]), .o_ibus_adr(adr_o[3]));

  function automatic int w_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic bit withc_of(input int k);
    return (k == 0) || (k == 1);
  endfunction

  function automatic bit vect_of(input int k);
    return (k == 0) || (k == 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ctl(input logic j, input logic jl, input logic u, input logic r,
                         input logic t, input logic q, input logic c);
    jump = j; jal = jl; utype = u; pc_rel = r; trap = t; irq = q; iscomp = c;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      pc_m[k]  = 32'h100;
      mis_m[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pc_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("rst_adr", adr_o[k], 32'h100);
      check("rst_mis", 32'(mis_o[k]), 32'h0);
    end
  endtask

  // One full update on DUT k with an optional stall of stall_len cycles before slice stall_at.
  task automatic run_update(input int k, input int stall_at, input int stall_len,
                            output logic [31:0] rd_got);
    int          w, n;
    logic [31:0] pc, inc, sum, al, vec, pinc, npc, rd_exp, bad_got, done_bits;
    logic        mis_new;
    w   = w_of(k);
    n   = 32 / w;
    pc  = pc_m[k];
    inc = (withc_of(k) && iscomp) ? 32'd2 : 32'd4;
    pinc = pc + inc;
    sum = (pc_rel ? pc : 32'h0) + (utype ? (imm32 & 32'hFFFF_F000) : buf32);
    al  = sum & ~32'h1;
    vec = (csr32 & ~32'h3) + ((vect_of(k) && irq) ? (32'(cause) << 2) : 32'h0);
    npc = trap ? vec : (jump ? al : pinc);
    rd_exp  = (utype ? al : 32'h0) | (jal ? pinc : 32'h0);
    mis_new = !withc_of(k) && jump && al[1];
    rd_got = '0; bad_got = '0; done_bits = '0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk);
          pc_en[k] = 1'b0;
        end
      end
      @(negedge clk);
      s = i;
      pc_en[k] = 1'b1;
      #1;
      if (i == 0) check("mis_hold", 32'(mis_o[k]), 32'(mis_m[k]));
      if (i == 1) check("mis_clr", 32'(mis_o[k]), 32'h0);
      rd_got       = rd_got | (rd_o[k] << (i * w));
      bad_got      = bad_got | (bad_o[k] << (i * w));
      done_bits[i] = done_o[k];
    end
    @(negedge clk);
    pc_en[k] = 1'b0;
    #1;
    pc_m[k]  = npc;
    mis_m[k] = mis_new;
    check("done", done_bits, 32'h1 << (n - 1));
    check("rd", rd_got, rd_exp);
    check("bad_pc", bad_got, al);
    check("adr", adr_o[k], npc);
    check("mis", 32'(mis_o[k]), 32'(mis_new));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd_got;
    int          k, n;
    rst_n = 1'b0; pc_en = '0; s = 0; cause = '0;
    imm32 = '0; buf32 = '0; csr32 = '0;
    set_ctl(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    do_reset();

    set_ctl(0, 0, 0, 0, 0, 0, 0);
    run_update(0, -1, 0, rd_got);
    check("w1_inc4", adr_o[0], 32'h104);

    do_reset();
    set_ctl(0, 0, 0, 0, 0, 0, 1);
    run_update(0, -1, 0, rd_got);
    check("w1_inc2", adr_o[0], 32'h102);
    run_update(1, -1, 0, rd_got);
    check("w4_inc2", adr_o[1], 32'h102);

    set_ctl(1, 1, 0, 1, 0, 0, 0);
    buf32 = 32'h0000_0FF0;
    run_update(2, -1, 0, rd_got);
    check("w8_jump", adr_o[2], 32'h10F0);
    check("w8_jal_rd", rd_got, 32'h104);
    check("w8_jump_mis", 32'(mis_o[2]), 32'h0);

    set_ctl(0, 0, 0, 0, 1, 1, 0);
    csr32 = 32'h8000_0001; cause = 5'd7;
    run_update(0, -1, 0, rd_got);
    check("vec_irq", adr_o[0], 32'h8000_001C);
    irq = 1'b0;
    run_update(0, -1, 0, rd_got);
    check("vec_exc", adr_o[0], 32'h8000_0000);

    do_reset();
    set_ctl(1, 0, 0, 1, 0, 0, 0);
    buf32 = 32'h2;
    run_update(2, -1, 0, rd_got);
    check("mis_pc", adr_o[2], 32'h102);
    check("mis_set", 32'(mis_o[2]), 32'h1);
    set_ctl(0, 0, 0, 0, 0, 0, 0);
    run_update(2, -1, 0, rd_got);
    set_ctl(1, 0, 0, 0, 0, 0, 0);
    buf32 = 32'h0000_2006;
    run_update(3, -1, 0, rd_got);
    check("w32_mis", 32'(mis_o[3]), 32'h1);

    // Reset lands at step 5 of a W=1 update that already stalled for 3 cycles.
    do_reset();
    set_ctl(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        repeat (3) begin
          @(negedge clk);
          pc_en[0] = 1'b0;
        end
      end
      @(negedge clk);
      s = i;
      pc_en[0] = 1'b1;
      if (i == 5) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    pc_en = '0;
    model_reset();
    #1;
    check("midrst_adr", adr_o[0], 32'h100);
    run_update(0, -1, 0, rd_got);
    check("midrst_next", adr_o[0], 32'h104);

    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, NDUT - 1);
      n = 32 / w_of(k);
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
      imm32 = $urandom;
      buf32 = $urandom;
      csr32 = $urandom;
      cause = 5'($urandom);
      run_update(k, $urandom_range(0, n), $urandom_range(0, 3), rd_got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
